// File: rtl/main_mem_arbiter_pkg.sv
// Shared types and constants for the MainMem arbiter between the CPU fetch and data ports.
// Access-type encoding matches the CPU's DiatRead/DiatWrite values.
package main_mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   localparam logic DIAT_READ  = 1'b0;
   localparam logic DIAT_WRITE = 1'b1;

   typedef enum logic {
      GRANT_IFETCH = 1'b0,
      GRANT_DATA   = 1'b1
   } arb_grant_t;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        access_type;
   } port_in_t;

   typedef struct packed {
      logic        ack;
      logic [31:0] data;
   } port_out_t;

   // Bit 0 is the fetch port, bit 1 the data port, matching the enum values.
   function automatic logic [1:0] grant_onehot(input arb_grant_t g);
      return (g == GRANT_DATA) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/main_mem_arbiter_rr_picker.sv
// Combinational 2-way round-robin pick: a lone candidate wins, a tie goes to the
// port that was not granted last. Masked requests are never candidates.
module main_mem_arbiter_rr_picker
   import main_mem_arbiter_pkg::*;
(
   input  logic [1:0] reqs,
   input  logic [1:0] mask,
   input  arb_grant_t last_grant,
   output arb_grant_t grant,
   output logic       valid
);

   logic [1:0] cand;

   always_comb begin
      cand  = reqs & ~mask;
      valid = |cand;
      grant = GRANT_DATA;
      if (cand == 2'b11)
         grant = (last_grant == GRANT_DATA) ? GRANT_IFETCH : GRANT_DATA;
      else if (cand == 2'b01)
         grant = GRANT_IFETCH;
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// Serialises CPU fetch and load/store traffic onto the single MainMem port and
// runs the req_mem_access / wait_for_mem handshake with a WAIT timeout.
module main_mem_arbiter
   import main_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int WIDTH_TIMEOUT  = 8
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_ifetch_req,
   input  logic [31:0] in_ifetch_addr,
   output logic        out_ifetch_ack,
   output logic [31:0] out_ifetch_data,
   input  logic        in_data_req,
   input  logic [31:0] in_data_addr,
   input  logic [31:0] in_data_wdata,
   input  logic        in_data_access_type,
   output logic        out_data_ack,
   output logic [31:0] out_data_rdata,
   output logic        out_mem_req_mem_access,
   output logic [31:0] out_mem_addr,
   output logic [31:0] out_mem_data,
   output logic        out_mem_access_type,
   input  logic        in_mem_wait_for_mem,
   input  logic [31:0] in_mem_data,
   output logic        out_busy,
   output logic        out_timeout_err,
   output logic [1:0]  dbg_state
);

   localparam logic [WIDTH_TIMEOUT-1:0] TMO_LAST = WIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

   port_in_t   ifetch_in, data_in, granted_in;
   port_out_t  ifetch_out, data_out;
   logic [1:0] state, state_nxt, pick_mask;
   arb_grant_t last_grant, cur_grant, pick_grant;
   logic       pick_valid, grant_now, wait_done, wait_tmo;
   logic [WIDTH_TIMEOUT-1:0] tmo_cnt;

   // Fetches are always reads with zero write data.
   assign ifetch_in  = '{req: in_ifetch_req, addr: in_ifetch_addr, wdata: 32'd0,
                         access_type: DIAT_READ};
   assign data_in    = '{req: in_data_req, addr: in_data_addr, wdata: in_data_wdata,
                         access_type: in_data_access_type};
   assign granted_in = (pick_grant == GRANT_DATA) ? data_in : ifetch_in;

   // In ACK the just-served port is masked, so the other port can be granted
   // straight away and alternating traffic keeps a 6-cycle cadence.
   assign pick_mask = (state == ST_ACK) ? grant_onehot(cur_grant) : 2'b00;

   main_mem_arbiter_rr_picker u_picker (
      .reqs       ({data_in.req, ifetch_in.req}),
      .mask       (pick_mask),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .valid      (pick_valid)
   );

   always_comb begin
      grant_now = pick_valid && !in_mem_wait_for_mem &&
                  ((state == ST_IDLE) || (state == ST_ACK));
      wait_done = (state == ST_WAIT) && !in_mem_wait_for_mem;
      wait_tmo  = (state == ST_WAIT) && in_mem_wait_for_mem && (tmo_cnt == TMO_LAST);
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ACK: state_nxt = grant_now ? ST_ISSUE : ST_IDLE;
         ST_ISSUE:        state_nxt = ST_WAIT;
         ST_WAIT:         if (wait_done || wait_tmo) state_nxt = ST_ACK;
         default:         state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= ST_IDLE;
         out_busy               <= 1'b0;
         last_grant             <= GRANT_IFETCH;
         cur_grant              <= GRANT_IFETCH;
         tmo_cnt                <= '0;
         out_timeout_err        <= 1'b0;
         out_mem_req_mem_access <= 1'b0;
         out_mem_addr           <= '0;
         out_mem_data           <= '0;
         out_mem_access_type    <= DIAT_READ;
         ifetch_out             <= '0;
         data_out               <= '0;
      end else begin
         state                  <= state_nxt;
         out_busy               <= (state_nxt != ST_IDLE);
         out_mem_req_mem_access <= grant_now;
         ifetch_out.ack         <= 1'b0;
         data_out.ack           <= 1'b0;

         if (grant_now) begin
            cur_grant           <= pick_grant;
            out_mem_addr        <= granted_in.addr;
            out_mem_data        <= granted_in.wdata;
            out_mem_access_type <= granted_in.access_type;
         end

         if (state == ST_ACK)
            last_grant <= cur_grant;

         if (state == ST_ISSUE)
            tmo_cnt <= '0;
         else if ((state == ST_WAIT) && in_mem_wait_for_mem)
            tmo_cnt <= tmo_cnt + WIDTH_TIMEOUT'(1);

         // An abandoned transaction returns zero data but still acks the requester.
         if (wait_done || wait_tmo) begin
            if (cur_grant == GRANT_DATA) begin
               data_out.ack  <= 1'b1;
               data_out.data <= wait_done ? in_mem_data : 32'd0;
            end else begin
               ifetch_out.ack  <= 1'b1;
               ifetch_out.data <= wait_done ? in_mem_data : 32'd0;
            end
            if (wait_tmo)
               out_timeout_err <= 1'b1;
         end
      end
   end

   assign out_ifetch_ack  = ifetch_out.ack;
   assign out_ifetch_data = ifetch_out.data;
   assign out_data_ack    = data_out.ack;
   assign out_data_rdata  = data_out.data;
   assign dbg_state       = state;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a behavioural MainMem (3-count sequencer,
// adjustable latency, optional hang) and hand-computed expectations.
module tb_main_mem_arbiter;
   import main_mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_ifetch_req = 1'b0;
   logic [31:0] in_ifetch_addr = '0;
   logic        out_ifetch_ack;
   logic [31:0] out_ifetch_data;
   logic        in_data_req = 1'b0;
   logic [31:0] in_data_addr = '0;
   logic [31:0] in_data_wdata = '0;
   logic        in_data_access_type = 1'b0;
   logic        out_data_ack;
   logic [31:0] out_data_rdata;
   logic        out_mem_req_mem_access;
   logic [31:0] out_mem_addr;
   logic [31:0] out_mem_data;
   logic        out_mem_access_type;
   logic        in_mem_wait_for_mem;
   logic [31:0] in_mem_data;
   logic        out_busy;
   logic        out_timeout_err;
   logic [1:0]  dbg_state;

   // Behavioural MainMem
   logic        mem_busy  = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [7:0]  mem_idx   = '0;
   int          mem_cnt   = 0;
   int          mem_lat   = 2;
   bit          mem_hang  = 1'b0;
   logic [31:0] mem_arr [0:255];

   int n_cmp = 0, n_err = 0;
   int n_if_ack = 0, n_d_ack = 0;

   main_mem_arbiter #(.TIMEOUT_CYCLES(8), .WIDTH_TIMEOUT(8)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .in_ifetch_req          (in_ifetch_req),
      .in_ifetch_addr         (in_ifetch_addr),
      .out_ifetch_ack         (out_ifetch_ack),
      .out_ifetch_data        (out_ifetch_data),
      .in_data_req            (in_data_req),
      .in_data_addr           (in_data_addr),
      .in_data_wdata          (in_data_wdata),
      .in_data_access_type    (in_data_access_type),
      .out_data_ack           (out_data_ack),
      .out_data_rdata         (out_data_rdata),
      .out_mem_req_mem_access (out_mem_req_mem_access),
      .out_mem_addr           (out_mem_addr),
      .out_mem_data           (out_mem_data),
      .out_mem_access_type    (out_mem_access_type),
      .in_mem_wait_for_mem    (in_mem_wait_for_mem),
      .in_mem_data            (in_mem_data),
      .out_busy               (out_busy),
      .out_timeout_err        (out_timeout_err),
      .dbg_state              (dbg_state)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   assign in_mem_wait_for_mem = mem_busy;
   assign in_mem_data         = mem_rdata;

   // Request seen -> wait_for_mem high; drops after mem_lat+1 further edges.
   always @(posedge clk) begin
      if (out_mem_req_mem_access) begin
         mem_busy <= 1'b1;
         mem_cnt  <= mem_lat;
         mem_idx  <= out_mem_addr[9:2];
         if (out_mem_access_type == DIAT_WRITE)
            mem_arr[out_mem_addr[9:2]] = out_mem_data;
      end else if (mem_busy && (mem_cnt == 0) && !mem_hang) begin
         mem_busy  <= 1'b0;
         mem_rdata <= mem_arr[mem_idx];
      end else if (mem_busy && (mem_cnt != 0)) begin
         mem_cnt <= mem_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (out_ifetch_ack === 1'b1) n_if_ack++;
      if (out_data_ack === 1'b1)   n_d_ack++;
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Cycles counted from the caller's current point; -1 if no ack within budget.
   task automatic wait_ack(input int budget, output int cycles, output logic [1:0] who);
      int k;
      k      = 0;
      cycles = -1;
      who    = 2'b00;
      while (k < budget) begin
         tick();
         k++;
         if (out_ifetch_ack || out_data_ack) begin
            cycles = k;
            who    = {out_ifetch_ack, out_data_ack};
            break;
         end
      end
   endtask

   // Tests
   task automatic test_reset();
      apply_reset();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({out_ifetch_ack, out_data_ack, out_mem_req_mem_access, out_busy,
           out_timeout_err, out_mem_access_type} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 000000", {out_ifetch_ack, out_data_ack,
                  out_mem_req_mem_access, out_busy, out_timeout_err, out_mem_access_type});
      end
      n_cmp++;
      if ({out_mem_addr, out_mem_data, out_ifetch_data, out_data_rdata} !== 128'd0) begin
         n_err++;
         $display("FAIL reset_data: got %h %h %h %h want all 0", out_mem_addr, out_mem_data,
                  out_ifetch_data, out_data_rdata);
      end
      n_cmp++;
      if (dbg_state !== ST_IDLE) begin
         n_err++;
         $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (out_busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_busy: got %b want 0", out_busy);
      end
   endtask

   task automatic test_single_fetch();
      int cyc;
      logic [1:0] who;
      int base_d;
      base_d         = n_d_ack;
      in_ifetch_addr = 32'h10;
      in_ifetch_req  = 1'b1;
      wait_ack(40, cyc, who);
      in_ifetch_req = 1'b0;
      n_cmp++;
      if (cyc !== 6) begin
         n_err++;
         $display("FAIL fetch_latency: got %0d want 6", cyc);
      end
      n_cmp++;
      if (who !== 2'b10) begin
         n_err++;
         $display("FAIL fetch_who: got %b want 10", who);
      end
      n_cmp++;
      if (out_ifetch_data !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL fetch_data: got %h want deadbeef", out_ifetch_data);
      end
      n_cmp++;
      if ({out_mem_addr, out_mem_data, out_mem_access_type} !== {32'h10, 32'h0, DIAT_READ}) begin
         n_err++;
         $display("FAIL fetch_mem_fields: got %h %h %b want 10 0 0", out_mem_addr,
                  out_mem_data, out_mem_access_type);
      end
      tick();
      n_cmp++;
      if (out_ifetch_ack !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_ack_pulse: got %b want 0", out_ifetch_ack);
      end
      n_cmp++;
      if (n_d_ack !== base_d) begin
         n_err++;
         $display("FAIL fetch_no_data_ack: got %0d want %0d", n_d_ack, base_d);
      end
      tick();
   endtask

   task automatic test_write_read();
      int cyc;
      logic [1:0] who;
      in_data_addr        = 32'h20;
      in_data_wdata       = 32'h12345678;
      in_data_access_type = DIAT_WRITE;
      in_data_req         = 1'b1;
      wait_ack(40, cyc, who);
      in_data_req = 1'b0;
      n_cmp++;
      if ({cyc, who} !== {32'd6, 2'b01}) begin
         n_err++;
         $display("FAIL write_ack: got cyc %0d who %b want 6 01", cyc, who);
      end
      n_cmp++;
      if ({out_mem_addr, out_mem_data, out_mem_access_type} !== {32'h20, 32'h12345678, DIAT_WRITE}) begin
         n_err++;
         $display("FAIL write_mem_fields: got %h %h %b want 20 12345678 1", out_mem_addr,
                  out_mem_data, out_mem_access_type);
      end
      tick();
      // Read back; address changed after grant must not matter.
      in_data_access_type = DIAT_READ;
      in_data_req         = 1'b1;
      tick();
      in_data_addr = 32'h10;
      wait_ack(40, cyc, who);
      in_data_req = 1'b0;
      n_cmp++;
      if ({cyc, who} !== {32'd5, 2'b01}) begin
         n_err++;
         $display("FAIL read_ack: got cyc %0d who %b want 5 01", cyc, who);
      end
      n_cmp++;
      if (out_data_rdata !== 32'h12345678) begin
         n_err++;
         $display("FAIL read_data: got %h want 12345678", out_data_rdata);
      end
      n_cmp++;
      if ({out_mem_addr, out_mem_access_type} !== {32'h20, DIAT_READ}) begin
         n_err++;
         $display("FAIL read_latched: got %h %b want 20 0", out_mem_addr, out_mem_access_type);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [1:0] who;
      int base_i, base_d;
      logic [1:0] exp_who [3];
      exp_who[0] = 2'b01;
      exp_who[1] = 2'b10;
      exp_who[2] = 2'b01;
      apply_reset();
      base_i              = n_if_ack;
      base_d              = n_d_ack;
      in_ifetch_addr      = 32'h10;
      in_data_addr        = 32'h20;
      in_data_access_type = DIAT_READ;
      in_ifetch_req       = 1'b1;
      in_data_req         = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ack(40, cyc, who);
         if (i == 2) begin
            in_ifetch_req = 1'b0;
            in_data_req   = 1'b0;
         end
         n_cmp++;
         if ({cyc, who} !== {32'd6, exp_who[i]}) begin
            n_err++;
            $display("FAIL b2b_ack%0d: got cyc %0d who %b want 6 %b", i, cyc, who, exp_who[i]);
         end
         if (i == 0) begin
            n_cmp++;
            if (out_data_rdata !== 32'h12345678) begin
               n_err++;
               $display("FAIL b2b_data: got %h want 12345678", out_data_rdata);
            end
         end
         if (i == 1) begin
            n_cmp++;
            if (out_ifetch_data !== 32'hDEADBEEF) begin
               n_err++;
               $display("FAIL b2b_fetch: got %h want deadbeef", out_ifetch_data);
            end
         end
      end
      repeat (8) tick();
      n_cmp++;
      if ({n_if_ack - base_i, n_d_ack - base_d} !== {32'd1, 32'd2}) begin
         n_err++;
         $display("FAIL b2b_counts: got if %0d data %0d want 1 2", n_if_ack - base_i, n_d_ack - base_d);
      end
   endtask

   task automatic test_held_req();
      int cyc;
      logic [1:0] who;
      int base_d;
      base_d              = n_d_ack;
      in_data_addr        = 32'h10;
      in_data_access_type = DIAT_READ;
      in_data_req         = 1'b1;
      wait_ack(40, cyc, who);
      n_cmp++;
      if ({cyc, who, out_data_rdata} !== {32'd6, 2'b01, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL held_first: got cyc %0d who %b data %h want 6 01 deadbeef", cyc, who, out_data_rdata);
      end
      tick();
      n_cmp++;
      if ({dbg_state, out_mem_req_mem_access} !== {ST_IDLE, 1'b0}) begin
         n_err++;
         $display("FAIL held_after_ack: got state %0d req %b want 0 0", dbg_state, out_mem_req_mem_access);
      end
      tick();
      n_cmp++;
      if ({dbg_state, out_mem_req_mem_access} !== {ST_ISSUE, 1'b1}) begin
         n_err++;
         $display("FAIL held_reissue: got state %0d req %b want 1 1", dbg_state, out_mem_req_mem_access);
      end
      wait_ack(40, cyc, who);
      in_data_req = 1'b0;
      n_cmp++;
      if ({cyc, who} !== {32'd5, 2'b01}) begin
         n_err++;
         $display("FAIL held_second: got cyc %0d who %b want 5 01", cyc, who);
      end
      repeat (8) tick();
      n_cmp++;
      if (n_d_ack - base_d !== 2) begin
         n_err++;
         $display("FAIL held_ack_count: got %0d want 2", n_d_ack - base_d);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      logic [1:0] who;
      mem_hang       = 1'b1;
      in_ifetch_addr = 32'h10;
      in_ifetch_req  = 1'b1;
      wait_ack(40, cyc, who);
      in_ifetch_req = 1'b0;
      n_cmp++;
      if ({cyc, who} !== {32'd10, 2'b10}) begin
         n_err++;
         $display("FAIL tmo_ack: got cyc %0d who %b want 10 10", cyc, who);
      end
      n_cmp++;
      if ({out_ifetch_data, out_timeout_err} !== {32'h0, 1'b1}) begin
         n_err++;
         $display("FAIL tmo_result: got data %h err %b want 0 1", out_ifetch_data, out_timeout_err);
      end
      repeat (4) tick();
      mem_hang            = 1'b0;
      in_data_addr        = 32'h20;
      in_data_access_type = DIAT_READ;
      in_data_req         = 1'b1;
      wait_ack(40, cyc, who);
      in_data_req = 1'b0;
      n_cmp++;
      if ({who, out_data_rdata, out_timeout_err} !== {2'b01, 32'h12345678, 1'b1}) begin
         n_err++;
         $display("FAIL tmo_sticky: got who %b data %h err %b want 01 12345678 1", who,
                  out_data_rdata, out_timeout_err);
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (out_timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_clear: got %b want 0", out_timeout_err);
      end
      tick();
   endtask

   task automatic test_rst_in_wait();
      int cyc;
      logic [1:0] who;
      int base_d;
      int k;
      bit early;
      bit saw_wait;
      base_d              = n_d_ack;
      mem_lat             = 12;
      in_data_addr        = 32'h20;
      in_data_access_type = DIAT_READ;
      in_data_req         = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (dbg_state !== ST_WAIT) begin
         n_err++;
         $display("FAIL rstw_pre: got state %0d want %0d", dbg_state, ST_WAIT);
      end
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      mem_lat = 2;
      n_cmp++;
      if ({out_ifetch_ack, out_data_ack, out_mem_req_mem_access, out_busy, out_timeout_err,
           out_mem_addr, out_data_rdata, dbg_state} !== {5'b0, 32'h0, 32'h0, ST_IDLE}) begin
         n_err++;
         $display("FAIL rstw_outputs: got acks %b%b req %b busy %b addr %h rdata %h state %0d want all 0",
                  out_ifetch_ack, out_data_ack, out_mem_req_mem_access, out_busy, out_mem_addr,
                  out_data_rdata, dbg_state);
      end
      k        = 0;
      early    = 1'b0;
      saw_wait = in_mem_wait_for_mem;
      while ((in_mem_wait_for_mem === 1'b1) && (k < 40)) begin
         if (out_mem_req_mem_access !== 1'b0) early = 1'b1;
         tick();
         k++;
      end
      n_cmp++;
      if ({saw_wait, early} !== 2'b10) begin
         n_err++;
         $display("FAIL rstw_drain: got saw_wait %b early_issue %b want 1 0", saw_wait, early);
      end
      wait_ack(40, cyc, who);
      in_data_req = 1'b0;
      n_cmp++;
      if ({cyc, who, out_data_rdata} !== {32'd6, 2'b01, 32'h12345678}) begin
         n_err++;
         $display("FAIL rstw_resume: got cyc %0d who %b data %h want 6 01 12345678", cyc, who, out_data_rdata);
      end
      repeat (4) tick();
      n_cmp++;
      if (n_d_ack - base_d !== 1) begin
         n_err++;
         $display("FAIL rstw_ack_count: got %0d want 1", n_d_ack - base_d);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      mem_arr[4] = 32'hDEADBEEF;
      test_reset();
      test_single_fetch();
      test_write_read();
      test_back_to_back();
      test_held_req();
      test_timeout();
      test_rst_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
- Shares the single MainMem request port between the CPU instruction-fetch requester (read-only) and the data load/store requester (read/write).
- Serializes 32-bit transactions in round-robin order and sequences the MainMem req_mem_access / wait_for_mem handshake.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the Frost32 CPU core and MainMem.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before the transaction is abandoned (must be 1..255)
WIDTH_TIMEOUT, 8, timeout counter width

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
in_ifetch_req  input  1  instruction-fetch request, level, held until ack
in_ifetch_addr  input  32  fetch byte address
out_ifetch_ack  output  1  one-cycle pulse: out_ifetch_data valid
out_ifetch_data  output  32  fetched word
in_data_req  input  1  data request, level, held until ack
in_data_addr  input  32  data byte address
in_data_wdata  input  32  store data
in_data_access_type  input  1  PkgFrost32Cpu::DiatRead / DiatWrite
out_data_ack  output  1  one-cycle pulse: access complete, out_data_rdata valid for reads
out_data_rdata  output  32  load data
out_mem_req_mem_access  output  1  to MainMem req_mem_access
out_mem_addr  output  32  to MainMem addr
out_mem_data  output  32  to MainMem data (write data)
out_mem_access_type  output  1  to MainMem data_inout_access_type
in_mem_wait_for_mem  input  1  from MainMem wait_for_mem
in_mem_data  input  32  from MainMem data
out_busy  output  1  high in every state except IDLE
out_timeout_err  output  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Reset:
  - State is IDLE; every output is 0.
  - Round-robin pointer favours the data port.
  - Timeout counter is 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Acts when a candidate request exists AND in_mem_wait_for_mem==0. MainMem has no reset, so a transaction in flight across rst drains first.
  - Grant: one candidate goes to it. Both candidates go to the port not granted last.
  - On grant: latch addr, wdata and access type into the out_mem_* registers. Fetch grants always use DiatRead, and out_mem_data=0 for fetch. Record the grant and go to ISSUE.
- ISSUE:
  - out_mem_req_mem_access=1 for exactly this one cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - out_mem_req_mem_access=0; out_mem_addr, out_mem_data and out_mem_access_type are held stable.
  - While in_mem_wait_for_mem==1: increment the timeout counter.
  - When in_mem_wait_for_mem==0: register in_mem_data into the granted port's data output, pulse its ack, go to ACK.
  - If the counter reaches TIMEOUT_CYCLES first: drive data 0, pulse ack, set out_timeout_err, go to ACK.
- ACK:
  - Ack is high this cycle only; the data output holds until that port's next ack.
  - The granted port's req is masked this cycle. A requester must drop req in its ack cycle or it issues a new request.
  - Return to IDLE; flip the round-robin pointer away from the granted port.
- Latency with the current MainMem (3-count sequencer): req sampled at IDLE edge E → ack high in the cycle after edge E+5. Minimum back-to-back spacing is 6 cycles per transaction.
- Ungranted requests: a requester may withdraw req before being granted (request dropped, no ack). Fields are latched at grant, so address/data may change after grant without effect.
- rst mid-transaction: return to IDLE immediately, no ack issued, out_timeout_err cleared. The next issue waits for in_mem_wait_for_mem==0.
- Writes: ack also pulses; out_data_rdata takes whatever MainMem returns (don't-care for the requester).
- Address wrap: none applied here; MainMem masks the address.

Decomposition:
- PkgMainMemArbiter:
  - enum StMainMemArbiter {IDLE, ISSUE, WAIT, ACK}
  - enum ArbGrant {GrantIfetch, GrantData}
  - struct PortIn/PortOut for each requester side, mirroring PkgMainMem port structs.
- Reuse PkgFrost32Cpu::DiatRead/DiatWrite.
- One natural sub-module: main_mem_arbiter_rr_picker. It is combinational 2-way round-robin selection (reqs, pointer, mask → grant, valid), unit-testable alone.

Test Plan:
- Single fetch: ifetch_req=1, addr=0x10, mem returns 0xDEADBEEF → ifetch_ack one pulse 6 cycles after request, ifetch_data=0xDEADBEEF, data_ack never high.
- Data write then read: write 0x12345678 @0x20 (DiatWrite on out_mem_access_type, out_mem_data=0x12345678), then read @0x20 → data_rdata=0x12345678.
- Simultaneous reqs from reset, both held across their own acks as new requests: grants alternate data, ifetch, data; each ack 6 cycles apart; no port granted twice in a row.
- Held req after ack: data_req kept high through ack → second transaction starts (ISSUE) only after ACK; exactly one ack per transaction, no duplicate issue in the ack cycle.
- Timeout: mem model holds wait_for_mem=1 forever, TIMEOUT_CYCLES=8 → ack after 8 WAIT cycles, data=0, out_timeout_err=1 and stays 1 until rst.
- rst during WAIT: assert rst one cycle → all outputs 0, no ack; new request not issued until in_mem_wait_for_mem falls to 0, then completes normally.
